// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// processing one input bit per clock.  A conversion is requested with a
// start/ready handshake; the result is registered, held until the next
// conversion completes, and announced with a one-cycle valid pulse.  Values
// that do not fit in DIGITS decimal digits raise ovf, and bcd then carries
// the value modulo 10^DIGITS.
//
// Parameters:
//   WIDTH   binary input width in bits (>= 4)
//   DIGITS  number of BCD output digits (>= 1)
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, sampled only while ready=1
//   bin    in   unsigned binary operand, sampled on the accepting edge
//   ready  out  a start on the next edge will be accepted
//   busy   out  conversion in progress (always ~ready)
//   valid  out  one-cycle pulse when bcd/ovf/blank update
//   bcd    out  packed BCD result, digit i at [4i+3:4i], digit 0 = units
//   ovf    out  operand was >= 10^DIGITS
//   blank  out  leading-zero mask
//
// Build option:
//   BIN2BCD_BLANK_EN  when defined, blank[i]=1 if digit i and every higher
//                     digit are zero (blank[0] is always 0).  When undefined
//                     blank is tied to zero and no blanking logic exists.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t              state_r;
  state_t              state_s;

  // Shift register layout: {BCD digits, remaining binary bits}.
  logic [SR_W-1:0]     sr_r;
  logic [SR_W-1:0]     sr_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_s;
  logic                ovf_acc_r;
  logic                ovf_acc_s;

  logic [SR_W-1:0]     adj_s;
  logic [SR_W-1:0]     step_s;
  logic                last_step_s;
  logic                ovf_final_s;

  logic                ready_s;
  logic                valid_s;
  logic [BCD_W-1:0]    bcd_s;
  logic                ovf_s;
  logic [DIGITS-1:0]   blank_s;

  // Add 3 to every BCD digit that is 5 or more.  A corrected digit is at
  // most 12, so 4-bit arithmetic never carries between digits.
  function automatic logic [SR_W-1:0] add3_digits(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] res;
    logic [3:0]      dig;
    res = sr;
    for (int d = 0; d < DIGITS; d++) begin
      dig = sr[WIDTH + 4*d +: 4];
      if (dig >= 4'd5) begin
        res[WIDTH + 4*d +: 4] = dig + 4'd3;
      end else begin
        res[WIDTH + 4*d +: 4] = dig;
      end
    end
    return res;
  endfunction

`ifdef BIN2BCD_BLANK_EN
  // Leading-zero mask: a digit is blank when it and all digits above it are
  // zero.  The units digit is never blanked so a zero result still shows "0".
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] val);
    logic [DIGITS-1:0] mask;
    logic              zero_above;
    mask       = {DIGITS{1'b0}};
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (val[4*i +: 4] == 4'd0);
      mask[i]    = zero_above;
    end
    return mask;
  endfunction
`endif

  // One double-dabble step: correct digits, then shift left by one.  The
  // bit leaving the top of the top digit is the overflow indicator.
  always_comb begin
    adj_s       = add3_digits(sr_r);
    step_s      = {adj_s[SR_W-2:0], 1'b0};
    last_step_s = (cnt_r == CNT_W'(WIDTH - 1));
    ovf_final_s = ovf_acc_r | adj_s[SR_W-1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_CONV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (last_step_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CONV;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s = ST_CONV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values; results only change on the final step.
  always_comb begin
    sr_s      = sr_r;
    cnt_s     = cnt_r;
    ovf_acc_s = ovf_acc_r;
    bcd_s     = bcd;
    ovf_s     = ovf;
    blank_s   = blank;
    valid_s   = 1'b0;
    ready_s   = (state_s != ST_CONV);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sr_s      = {{BCD_W{1'b0}}, bin};
          cnt_s     = {CNT_W{1'b0}};
          ovf_acc_s = 1'b0;
        end else begin
          sr_s      = sr_r;
        end
      end
      ST_CONV: begin
        sr_s      = step_s;
        cnt_s     = cnt_r + CNT_W'(1);
        ovf_acc_s = ovf_final_s;
        if (last_step_s) begin
          bcd_s   = step_s[SR_W-1 -: BCD_W];
          ovf_s   = ovf_final_s;
          valid_s = 1'b1;
`ifdef BIN2BCD_BLANK_EN
          blank_s = blank_mask(step_s[SR_W-1 -: BCD_W]);
`else
          blank_s = {DIGITS{1'b0}};
`endif
        end else begin
          valid_s = 1'b0;
        end
      end
      default: begin
        sr_s = sr_r;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r      <= {SR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      ovf_acc_r <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      valid     <= 1'b0;
      bcd       <= {BCD_W{1'b0}};
      ovf       <= 1'b0;
      blank     <= {DIGITS{1'b0}};
    end else begin
      sr_r      <= sr_s;
      cnt_r     <= cnt_s;
      ovf_acc_r <= ovf_acc_s;
      ready     <= ready_s;
      busy      <= ~ready_s;
      valid     <= valid_s;
      bcd       <= bcd_s;
      ovf       <= ovf_s;
      blank     <= blank_s;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=10, DIGITS=4
  logic        start_a = 1'b0;
  logic [9:0]  bin_a = 10'd0;
  logic        ready_a, busy_a, valid_a, ovf_a;
  logic [15:0] bcd_a;
  logic [3:0]  blank_a;
  // Instance B: WIDTH=16, DIGITS=4
  logic        start_b = 1'b0;
  logic [15:0] bin_b = 16'd0;
  logic        ready_b, busy_b, valid_b, ovf_b;
  logic [15:0] bcd_b;
  logic [3:0]  blank_b;
  // Instance C: WIDTH=16, DIGITS=5
  logic        start_c = 1'b0;
  logic [15:0] bin_c = 16'd0;
  logic        ready_c, busy_c, valid_c, ovf_c;
  logic [19:0] bcd_c;
  logic [4:0]  blank_c;

  int n_checks = 0;
  int n_fail = 0;

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a), .ready(ready_a),
    .busy(busy_a), .valid(valid_a), .bcd(bcd_a), .ovf(ovf_a), .blank(blank_a));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b), .ready(ready_b),
    .busy(busy_b), .valid(valid_b), .bcd(bcd_b), .ovf(ovf_b), .blank(blank_b));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c), .ready(ready_c),
    .busy(busy_c), .valid(valid_c), .bcd(bcd_c), .ovf(ovf_c), .blank(blank_c));

  // Reference model: decimal digits from plain division.
  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] model_bcd(input int v, input int d);
    logic [19:0] r = 20'd0;
    int m = v % pow10(d);
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v, input int d);
    return (v >= pow10(d));
  endfunction

  function automatic logic [4:0] model_blank(input int v, input int d);
    logic [4:0] r = 5'd0;
`ifdef BIN2BCD_BLANK_EN
    int m = v % pow10(d);
    for (int i = 1; i < d; i++) r[i] = (m < pow10(i));
`endif
    return r;
  endfunction

  // Launch one conversion on instance sel and wait (bounded) for valid.
  task automatic conv(input int sel, input int v, output int lat,
                      output logic [19:0] b, output logic o, output logic [4:0] bl);
    @(negedge clk);
    case (sel)
      0: begin start_a = 1'b1; bin_a = 10'(v); end
      1: begin start_b = 1'b1; bin_b = 16'(v); end
      default: begin start_c = 1'b1; bin_c = 16'(v); end
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    lat = -1; b = 20'd0; o = 1'b0; bl = 5'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (sel == 0 && valid_a) begin
        lat = k; b = {4'h0, bcd_a}; o = ovf_a; bl = {1'b0, blank_a}; break;
      end else if (sel == 1 && valid_b) begin
        lat = k; b = {4'h0, bcd_b}; o = ovf_b; bl = {1'b0, blank_b}; break;
      end else if (sel == 2 && valid_c) begin
        lat = k; b = bcd_c; o = ovf_c; bl = blank_c; break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ready_a, busy_a, valid_a, ovf_a, bcd_a, blank_a} !== {4'b1000, 16'h0, 4'h0}) begin
      n_fail++; $display("FAIL reset_a got r%b b%b v%b o%b bcd=%h bl=%b", ready_a, busy_a, valid_a, ovf_a, bcd_a, blank_a);
    end
    n_checks++;
    if ({ready_b, busy_b, valid_b, ovf_b, bcd_b, blank_b} !== {4'b1000, 16'h0, 4'h0}) begin
      n_fail++; $display("FAIL reset_b got r%b b%b v%b o%b bcd=%h bl=%b", ready_b, busy_b, valid_b, ovf_b, bcd_b, blank_b);
    end
    n_checks++;
    if ({ready_c, busy_c, valid_c, ovf_c, bcd_c, blank_c} !== {4'b1000, 20'h0, 5'h0}) begin
      n_fail++; $display("FAIL reset_c got r%b b%b v%b o%b bcd=%h bl=%b", ready_c, busy_c, valid_c, ovf_c, bcd_c, blank_c);
    end
  endtask

  task automatic test_max10();
    int lat; logic [19:0] b; logic o; logic [4:0] bl;
    conv(0, 1023, lat, b, o, bl);
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL max10_latency got %0d exp 10", lat); end
    n_checks++; if (b !== 20'h01023) begin n_fail++; $display("FAIL max10_bcd got %h exp 01023", b); end
    n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL max10_ovf got %b exp 0", o); end
    n_checks++; if (bl !== 5'b00000) begin n_fail++; $display("FAIL max10_blank got %b exp 00000", bl); end
  endtask

  task automatic test_zero_blank();
    int lat; logic [19:0] b; logic o; logic [4:0] bl; logic [4:0] exp_bl;
`ifdef BIN2BCD_BLANK_EN
    exp_bl = 5'b01110;
`else
    exp_bl = 5'b00000;
`endif
    conv(0, 0, lat, b, o, bl);
    n_checks++; if (b !== 20'h0) begin n_fail++; $display("FAIL zero_bcd got %h exp 0", b); end
    n_checks++; if (bl !== exp_bl) begin n_fail++; $display("FAIL zero_blank got %b exp %b", bl, exp_bl); end
  endtask

  task automatic test_overflow();
    int lat; logic [19:0] b; logic o; logic [4:0] bl;
    conv(1, 65535, lat, b, o, bl);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL ovf_latency got %0d exp 16", lat); end
    n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", o); end
    n_checks++; if (b !== 20'h05535) begin n_fail++; $display("FAIL ovf_bcd got %h exp 05535", b); end
    conv(1, 9999, lat, b, o, bl);
    n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL ovf9999_flag got %b exp 0", o); end
    n_checks++; if (b !== 20'h09999) begin n_fail++; $display("FAIL ovf9999_bcd got %h exp 09999", b); end
  endtask

  task automatic test_random();
    int lat; logic [19:0] b; logic o; logic [4:0] bl;
    int sel, v, d;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(2, 1));
      v = (n < 4) ? int'($urandom_range(9, 0)) : int'($urandom_range(65535, 0));
      d = (sel == 1) ? 4 : 5;
      conv(sel, v, lat, b, o, bl);
      n_checks++;
      if (lat !== 16 || b !== model_bcd(v, d) || o !== model_ovf(v, d) || bl !== model_blank(v, d)) begin
        n_fail++;
        $display("FAIL random sel=%0d v=%0d got lat=%0d bcd=%h ovf=%b bl=%b exp lat=16 bcd=%h ovf=%b bl=%b",
                 sel, v, lat, b, o, bl, model_bcd(v, d), model_ovf(v, d), model_blank(v, d));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v; int idx, ev;
    @(negedge clk);
    start_c = 1'b1; bin_c = 16'd12345;
    @(posedge clk); #1;
    bin_c = 16'd40960;  // change mid-conversion; must not affect 12345
    for (int k = 1; k <= 67; k++) begin
      @(posedge clk); #1;
      exp_v = ((k % 17) == 16);
      n_checks++;
      if (valid_c !== exp_v || busy_c !== !exp_v || ready_c !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_handshake k=%0d got v%b b%b r%b exp v%b", k, valid_c, busy_c, ready_c, exp_v);
      end
      if (exp_v) begin
        idx = k / 17;
        ev = (idx % 2 == 1) ? 40960 : 12345;
        n_checks++;
        if (bcd_c !== model_bcd(ev, 5) || ovf_c !== 1'b0) begin
          n_fail++; $display("FAIL b2b_bcd k=%0d got %h ovf=%b exp %h", k, bcd_c, ovf_c, model_bcd(ev, 5));
        end
      end
      if (k % 17 == 0) bin_c = (((k / 17) % 2) == 1) ? 16'd12345 : 16'd40960;
      if (k == 67) start_c = 1'b0;
    end
    @(posedge clk); #1;
    n_checks++;
    if (ready_c !== 1'b1 || valid_c !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got r%b v%b exp r1 v0", ready_c, valid_c);
    end
  endtask

  task automatic test_abort();
    int lat; int seen; logic [19:0] b; logic o; logic [4:0] bl;
    @(negedge clk);
    start_c = 1'b1; bin_c = 16'd500;
    @(posedge clk); #1;
    start_c = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (busy_c !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b exp 1", busy_c); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready_c, busy_c, valid_c, ovf_c, bcd_c, blank_c} !== {4'b1000, 20'h0, 5'h0}) begin
      n_fail++; $display("FAIL abort_reset got r%b b%b v%b o%b bcd=%h bl=%b", ready_c, busy_c, valid_c, ovf_c, bcd_c, blank_c);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (valid_c) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid got %0d pulses exp 0", seen); end
    conv(2, 7, lat, b, o, bl);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL abort_restart_latency got %0d exp 16", lat); end
    n_checks++; if (b !== 20'h00007) begin n_fail++; $display("FAIL abort_restart_bcd got %h exp 00007", b); end
  endtask

  task automatic test_sweep();
    int lat; logic [19:0] b; logic o; logic [4:0] bl;
    for (int v = 0; v < 1024; v++) begin
      conv(0, v, lat, b, o, bl);
      n_checks++;
      if (lat !== 10 || b !== model_bcd(v, 4) || o !== 1'b0 || bl !== model_blank(v, 4)) begin
        n_fail++;
        $display("FAIL sweep v=%0d got lat=%0d bcd=%h ovf=%b bl=%b exp lat=10 bcd=%h ovf=0 bl=%b",
                 v, lat, b, o, bl, model_bcd(v, 4), model_blank(v, 4));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_max10();
    test_zero_blank();
    test_overflow();
    test_random();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock. It is the area-reduced, width-generic successor to the fixed 10-bit combinational converter and feeds the 7-segment display drivers. Input capture uses a start/ready handshake. Results are registered, held until the next conversion and flagged with a one-cycle valid pulse. A flag reports inputs that do not fit in the configured digit count.

## Interface
- WIDTH, 16: binary input width in bits; minimum 4.
- DIGITS, 5: number of BCD output digits; minimum 1.
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only when ready=1.
- bin  input  WIDTH  unsigned binary value; sampled on the edge that accepts start.
- ready  output  1  high when a start will be accepted.
- busy  output  1  high while converting; always equals ~ready.
- valid  output  1  one-cycle pulse when bcd/ovf/blank update.
- bcd  output  4*DIGITS  packed result; digit i at bits [4i+3:4i]; digit 0 is the units digit.
- ovf  output  1  input value ≥ 10^DIGITS; bcd then holds value mod 10^DIGITS.
- blank  output  DIGITS  leading-zero mask (see Configuration).

## Operation
- The FSM has three states: IDLE, CONV and DONE.
- IDLE: ready=1. If start=1, load shift register {DIGITS×4'b0, bin}, clear bit counter, clear the internal overflow accumulator, and go to CONV.
- CONV: ready=0. Each cycle performs one step on every digit of the BCD field:
  - add 3 to the digit if it is ≥5;
  - shift the whole register left by one.
- CONV overflow handling: the bit shifted out of the top of digit DIGITS-1 is ORed into the overflow accumulator and then discarded.
- CONV exit: after WIDTH steps, load bcd, ovf and blank from the register and accumulator, and go to DONE.
- DONE: valid=1 and ready=1. If start=1, begin a new conversion exactly as from IDLE. Otherwise go to IDLE.
- bcd, ovf and blank hold their values through IDLE and CONV until the next DONE.
- start with ready=0 is ignored; it is neither queued nor able to corrupt the conversion. bin changes during CONV have no effect.
- Counter width is $clog2(WIDTH+1). Digit arithmetic is 4-bit, and a corrected digit never exceeds 12 before the shift.

## Timing
- Reset values: state=IDLE, ready=1, busy=0, valid=0, bcd=0, ovf=0, blank=0, and the internal shift register and counter are 0.
- Latency: start accepted at edge t0 gives valid high in the cycle after edge t0+WIDTH, i.e. exactly WIDTH cycles later.
- Throughput: with start held high, one result every WIDTH+1 cycles, because start is accepted in DONE.
- rst_n asserted mid-CONV: all outputs return to reset values immediately (asynchronously). No valid is produced for the aborted conversion.
- rst_n deasserted: the first start can be accepted on the first rising edge after deassertion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- BIN2BCD_BLANK_EN defined:
  - blank[i]=1 when digit i and every higher digit are zero.
  - blank[0] is always 0.
  - blank is registered with bcd and updates only in DONE.
- BIN2BCD_BLANK_EN undefined: the blank port exists but is tied to 0, and no blanking logic is synthesised.

## Test plan
- WIDTH=10, DIGITS=4, bin=1023, one-cycle start: valid exactly 10 cycles after the accepting edge; bcd=16'h1023, ovf=0, blank=4'b0000.
- WIDTH=10, DIGITS=4, bin=0 with BIN2BCD_BLANK_EN: bcd=16'h0000, blank=4'b1110. The same run without the macro gives blank=0.
- WIDTH=16, DIGITS=4, bin=65535: ovf=1, bcd=16'h5535. Then bin=9999 gives ovf=0, bcd=16'h9999.
- WIDTH=16, DIGITS=5: start held high with bin alternating 12345 and 40960.
  - Outputs: valid pulses every 17 cycles with bcd=20'h12345 then 20'h40960.
  - Extra start pulses during busy are ignored, and a bin change mid-CONV does not alter the result.
- WIDTH=16, DIGITS=5, rst_n low 5 cycles after start of bin=500: all outputs are 0 immediately and no valid pulse occurs. A fresh start of bin=7 then gives bcd=20'h00007 after 16 cycles.
- Exhaustive sweep for WIDTH=10, DIGITS=4, bin=0..1023: every result is compared with a reference decimal model, and ovf stays 0.
